// File: rtl/fan_psum_accum_pkg.sv
// Shared types and default sizing for the FAN partial-sum accumulator.
package fan_psum_accum_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_PES    = 32;
  localparam int DEF_LOG2_FOLDS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/fan_psum_accum_if.sv
// Slot-vector stream: one word per output slot plus a per-slot written mask.
// A beat transfers on the rising edge where valid & ready are both high; the
// master keeps valid/data/mask stable until that edge, ready may change freely.
interface fan_psum_accum_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PES    = 32
);
  logic                          valid;
  logic                          ready;
  logic [NUM_PES*DATA_WIDTH-1:0] data;
  logic [NUM_PES-1:0]            mask;

  modport master (output valid, output data, output mask, input ready);
  modport slave  (input valid, input data, input mask, output ready);
endinterface

// File: rtl/fan_psum_lane.sv
// One slot accumulator: the first accepted beat loads, later beats add (mod 2^W).
module fan_psum_lane
  import fan_psum_accum_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  first_i,
  input  logic                  mask_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] acc_o
);

  logic [DATA_WIDTH-1:0] acc_q, acc_d, addend;

  always_comb begin
    addend = mask_i ? data_i : '0;
    acc_d  = acc_q;
    if (en_i) begin
      acc_d = first_i ? addend : (acc_q + addend);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fan_psum_accum.sv
// Accumulates reordered slot vectors over a programmed fold count and hands the
// finished vector downstream, holding off new beats until it is taken.
module fan_psum_accum
  import fan_psum_accum_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_PES    = DEF_NUM_PES,
  parameter int LOG2_FOLDS = DEF_LOG2_FOLDS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_cfg_start,
  input  logic [LOG2_FOLDS-1:0] i_cfg_folds,
  fan_psum_accum_if.slave       in_if,
  fan_psum_accum_if.master      out_if,
  output logic                  o_busy,
  output logic                  o_done,
  output state_e                o_state
);

  state_e                state_q;
  logic [LOG2_FOLDS-1:0] folds_q, cnt_q;
  logic [NUM_PES-1:0]    mask_q;
  logic                  done_q;
  logic                  accept, first_beat, last_beat;

  assign accept     = in_if.valid && (state_q == ACCUM);
  assign first_beat = (cnt_q == '0);
  assign last_beat  = (cnt_q == (folds_q - LOG2_FOLDS'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      folds_q <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_cfg_start) begin
            // A zero fold count still means one beat per result.
            folds_q <= (i_cfg_folds == '0) ? LOG2_FOLDS'(1) : i_cfg_folds;
            cnt_q   <= '0;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            cnt_q  <= cnt_q + LOG2_FOLDS'(1);
            mask_q <= first_beat ? in_if.mask : (mask_q | in_if.mask);
            if (last_beat) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_if.ready) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_PES; k++) begin : g_lane
    fan_psum_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (accept),
      .first_i (first_beat),
      .mask_i  (in_if.mask[k]),
      .data_i  (in_if.data[k*DATA_WIDTH +: DATA_WIDTH]),
      .acc_o   (out_if.data[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign in_if.ready  = (state_q == ACCUM);
  assign out_if.valid = (state_q == DRAIN);
  assign out_if.mask  = mask_q;
  assign o_busy       = (state_q != IDLE);
  assign o_done       = done_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_fan_psum_accum.sv
// Bench for fan_psum_accum: directed table, hand sequences and random results
// checked against an arithmetic sum-of-masked-beats model.
module tb_fan_psum_accum;
  import fan_psum_accum_pkg::*;

  localparam int DW = 32;
  localparam int NP = 32;
  localparam int NW = DW * NP;
  localparam int LF = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_start;
  logic [LF-1:0] cfg_folds;
  logic          busy, done;
  state_e        st;

  fan_psum_accum_if #(.DATA_WIDTH(DW), .NUM_PES(NP)) in_if ();
  fan_psum_accum_if #(.DATA_WIDTH(DW), .NUM_PES(NP)) out_if ();

  fan_psum_accum dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cfg_start (cfg_start),
    .i_cfg_folds (cfg_folds),
    .in_if       (in_if),
    .out_if      (out_if),
    .o_busy      (busy),
    .o_done      (done),
    .o_state     (st)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [NW-1:0] exp_q[$];
  logic [NP-1:0] expm_q[$];

  logic [NW-1:0] bd [8];
  logic [NP-1:0] bm [8];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkm(input string name, input logic [NP-1:0] act, input logic [NP-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NW-1:0] rand_vec();
    logic [NW-1:0] v;
    for (int k = 0; k < NP; k++) v[k*DW +: DW] = $urandom;
    return v;
  endfunction

  // Reference: each slot is the mod-2^32 sum of its masked contributions,
  // the mask is the OR of all beat masks.
  function automatic void model_push(input int nb);
    logic [NW-1:0] sum;
    logic [NP-1:0] m;
    logic [DW-1:0] s;
    sum = '0;
    m   = '0;
    for (int k = 0; k < NP; k++) begin
      s = '0;
      for (int b = 0; b < nb; b++) if (bm[b][k]) s = s + bd[b][k*DW +: DW];
      sum[k*DW +: DW] = s;
    end
    for (int b = 0; b < nb; b++) m = m | bm[b];
    exp_q.push_back(sum);
    expm_q.push_back(m);
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start(input logic [LF-1:0] f);
    cfg_start    = 1'b1;
    cfg_folds    = f;
    in_if.valid  = 1'($urandom_range(0, 1));
    in_if.data   = rand_vec();
    in_if.mask   = NP'($urandom);
    tick();
    cfg_start    = 1'b0;
    in_if.valid  = 1'b0;
    chk1("start_busy", busy, 1'b1);
    chk1("start_ready", in_if.ready, 1'b1);
  endtask

  task automatic send_beats(input int nb, input int gap_max);
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_if.valid = 1'b0;
        in_if.data  = rand_vec();
        in_if.mask  = NP'($urandom);
        tick();
      end
      chk1("beat_ready", in_if.ready, 1'b1);
      chk1("early_valid", out_if.valid, 1'b0);
      in_if.valid = 1'b1;
      in_if.data  = bd[b];
      in_if.mask  = bm[b];
      tick();
      in_if.valid = 1'b0;
    end
  endtask

  // Called on the negedge right after the last beat's edge.
  task automatic finish_result(input int hold, input logic noisy, input int chain_folds);
    logic [NW-1:0] e;
    logic [NP-1:0] em;
    e  = exp_q.pop_front();
    em = expm_q.pop_front();
    chk1("valid_latency", out_if.valid, 1'b1);
    chk1("drain_ready", in_if.ready, 1'b0);
    for (int h = 0; h < hold; h++) begin
      if (noisy) begin
        in_if.valid = 1'b1;
        in_if.data  = rand_vec();
        in_if.mask  = NP'($urandom);
        cfg_start   = 1'b1;
        cfg_folds   = LF'($urandom_range(1, 5));
      end
      tick();
      chkv("hold_data", out_if.data, e);
      chk1("hold_valid", out_if.valid, 1'b1);
      chk1("hold_ready", in_if.ready, 1'b0);
      chk1("hold_state", st == DRAIN, 1'b1);
    end
    cfg_start   = 1'b0;
    in_if.valid = 1'b0;
    chkv("result_data", out_if.data, e);
    chkm("result_mask", out_if.mask, em);
    out_if.ready = 1'b1;
    tick();
    out_if.ready = 1'b0;
    chk1("done_pulse", done, 1'b1);
    chk1("valid_drop", out_if.valid, 1'b0);
    chk1("idle_busy", busy, 1'b0);
    chkv("data_keep", out_if.data, e);
    if (chain_folds >= 0) begin
      cfg_start = 1'b1;
      cfg_folds = LF'(chain_folds);
    end
    tick();
    cfg_start = 1'b0;
    chk1("done_clear", done, 1'b0);
    if (chain_folds >= 0) begin
      chk1("chain_busy", busy, 1'b1);
      chk1("chain_ready", in_if.ready, 1'b1);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [LF-1:0]      folds;
    int                 sa;
    int                 sb;
    logic [2:0][DW-1:0] da;
    logic [2:0][DW-1:0] db;
    logic [2:0]         ma;
    logic [2:0]         mb;
    logic [DW-1:0]      ea;
    logic [DW-1:0]      eb;
    logic [NP-1:0]      em;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [NW-1:0] e;
    int nb, f;

    tbl[0] = '{folds: 8'd3, sa: 0, sb: 1,
               da: {32'hFFFF_FFFE, 32'd7, 32'd5}, db: {32'd100, 32'd9, 32'd100},
               ma: 3'b111, mb: 3'b010, ea: 32'd10, eb: 32'd9, em: 32'h0000_0003};
    tbl[1] = '{folds: 8'd2, sa: 31, sb: 30,
               da: {32'd0, 32'd2, 32'hFFFF_FFFF}, db: {32'd0, 32'd8, 32'd7},
               ma: 3'b011, mb: 3'b000, ea: 32'd1, eb: 32'd0, em: 32'h8000_0000};
    tbl[2] = '{folds: 8'd0, sa: 5, sb: 6,
               da: {32'd0, 32'd0, 32'd42}, db: {32'd0, 32'd0, 32'd3},
               ma: 3'b001, mb: 3'b000, ea: 32'd42, eb: 32'd0, em: 32'h0000_0020};
    tbl[3] = '{folds: 8'd1, sa: 2, sb: 3,
               da: {32'd0, 32'd0, 32'h7FFF_FFFF}, db: {32'd0, 32'd0, 32'h8000_0000},
               ma: 3'b001, mb: 3'b001, ea: 32'h7FFF_FFFF, eb: 32'h8000_0000, em: 32'h0000_000C};
    tbl[4] = '{folds: 8'd3, sa: 10, sb: 11,
               da: {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, db: {32'd4, 32'd2, 32'd1},
               ma: 3'b111, mb: 3'b101, ea: 32'hFFFF_FFFD, eb: 32'd5, em: 32'h0000_0C00};
    tbl[5] = '{folds: 8'd2, sa: 20, sb: 21,
               da: {32'd0, 32'd3, 32'd9}, db: {32'd0, 32'd6, 32'd4},
               ma: 3'b010, mb: 3'b001, ea: 32'd3, eb: 32'd4, em: 32'h0030_0000};

    // ---------------- reset ----------------
    rst_n        = 1'b0;
    out_if.ready = 1'b0;
    repeat (3) begin
      cfg_start    = 1'($urandom_range(0, 1));
      cfg_folds    = LF'($urandom);
      in_if.valid  = 1'($urandom_range(0, 1));
      in_if.data   = rand_vec();
      in_if.mask   = NP'($urandom);
      out_if.ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk1("rst_valid", out_if.valid, 1'b0);
    chkv("rst_data", out_if.data, '0);
    chkm("rst_mask", out_if.mask, '0);
    chk1("rst_ready", in_if.ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    cfg_start    = 1'b0;
    in_if.valid  = 1'b0;
    out_if.ready = 1'b0;
    rst_n        = 1'b1;
    tick();

    // Beats offered in IDLE must be ignored.
    in_if.valid = 1'b1;
    repeat (2) tick();
    in_if.valid = 1'b0;
    chk1("idle_ignore_busy", busy, 1'b0);
    chk1("idle_ignore_ready", in_if.ready, 1'b0);

    // folds=1, slot k carries k, every slot written.
    for (int k = 0; k < NP; k++) bd[0][k*DW +: DW] = DW'(k);
    bm[0] = '1;
    e = '0;
    for (int k = 0; k < NP; k++) e[k*DW +: DW] = DW'(k);
    exp_q.push_back(e);
    expm_q.push_back(32'hFFFF_FFFF);
    do_start(8'd1);
    send_beats(1, 0);
    finish_result(0, 1'b0, -1);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      nb = (tbl[i].folds == 0) ? 1 : int'(tbl[i].folds);
      for (int b = 0; b < nb; b++) begin
        bd[b] = rand_vec();
        bd[b][tbl[i].sa*DW +: DW] = tbl[i].da[b];
        bd[b][tbl[i].sb*DW +: DW] = tbl[i].db[b];
        bm[b] = '0;
        bm[b][tbl[i].sa] = tbl[i].ma[b];
        bm[b][tbl[i].sb] = tbl[i].mb[b];
      end
      e = '0;
      e[tbl[i].sa*DW +: DW] = tbl[i].ea;
      e[tbl[i].sb*DW +: DW] = tbl[i].eb;
      exp_q.push_back(e);
      expm_q.push_back(tbl[i].em);
      do_start(tbl[i].folds);
      send_beats(nb, 1);
      finish_result(i % 3, 1'b1, -1);
    end

    // Backpressure for 4 cycles with noise, then a start in the o_done cycle.
    for (int b = 0; b < 2; b++) begin
      bd[b] = rand_vec();
      bm[b] = NP'($urandom);
    end
    model_push(2);
    do_start(8'd2);
    send_beats(2, 0);
    bd[0] = rand_vec();
    bm[0] = NP'($urandom);
    model_push(1);
    finish_result(4, 1'b1, 1);
    send_beats(1, 0);
    finish_result(0, 1'b0, -1);

    // Reset in the middle of accumulation.
    for (int b = 0; b < 2; b++) begin
      bd[b] = rand_vec();
      bm[b] = '1;
    end
    do_start(8'd4);
    send_beats(2, 0);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_valid", out_if.valid, 1'b0);
    chkv("mid_rst_data", out_if.data, '0);
    chkm("mid_rst_mask", out_if.mask, '0);
    chk1("mid_rst_ready", in_if.ready, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_done", done, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    bd[0] = rand_vec();
    bm[0] = NP'($urandom);
    model_push(1);
    do_start(8'd1);
    send_beats(1, 0);
    finish_result(0, 1'b0, -1);

    // Randomized results against the model.
    for (int r = 0; r < 20; r++) begin
      f  = $urandom_range(0, 6);
      nb = (f == 0) ? 1 : f;
      for (int b = 0; b < nb; b++) begin
        bd[b] = rand_vec();
        bm[b] = NP'($urandom);
      end
      model_push(nb);
      do_start(LF'(f));
      send_beats(nb, 2);
      finish_result($urandom_range(0, 2), 1'b1, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
